// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: HI/LO write selects,
// writeback selects and divider FSM states.
package md_pkg;

  localparam logic [1:0] SEL_RS   = 2'b00;
  localparam logic [1:0] SEL_MUL  = 2'b01;
  localparam logic [1:0] SEL_DIV  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam logic [1:0] M2RF_NONE = 2'd0;
  localparam logic [1:0] M2RF_MUL  = 2'd1;
  localparam logic [1:0] M2RF_HI   = 2'd2;
  localparam logic [1:0] M2RF_LO   = 2'd3;

  typedef logic [1:0] md_state_t;

  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_RUN  = 2'd1;
  localparam md_state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider on operand magnitudes: one quotient bit per clock,
// signs applied in a final fix-up cycle that also pulses done_o.
module md_divider
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  md_state_t        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    dvd_neg   = signed_i & dividend_i[WIDTH-1];
    dvs_neg   = signed_i & divisor_i[WIDTH-1];
    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          cnt_d     = CntLast;
          rem_d     = '0;
          quo_d     = dvd_neg ? -dividend_i : dividend_i;
          dvs_d     = dvs_neg ? -divisor_i : divisor_i;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
        end
      end
      ST_RUN: begin
        if (trial[WIDTH]) begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_FIX);
  assign quot_o = neg_quo_q ? -quo_q : quo_q;
  assign rem_o  = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/md_hilo_unit.sv
// Multiply/divide execution unit owning the HI/LO registers, the single-cycle
// multiplier, pipeline stall generation and the writeback read mux.
module md_hilo_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       multiply,
  input  logic [1:0]       divide,
  input  logic [1:0]       HI_sel,
  input  logic [1:0]       LO_sel,
  input  logic [1:0]       MultoRF,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] md_rdata,
  output logic             busy,
  output logic             stall
);

  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               mul_en, div_en, md_req, accept;
  logic               div_start, div_zero, div_busy, div_done;
  logic [2*WIDTH-1:0] op_a, op_b, product;
  logic [WIDTH-1:0]   div_quot, div_rem;

  // Divide wins if upstream ever asserts both enables
  assign div_en = divide[1];
  assign mul_en = multiply[1] & ~div_en;

  // Anything touching HI/LO or the divider must wait out an in-flight divide
  assign md_req = multiply[1] | divide[1] | (HI_sel != SEL_HOLD) | (LO_sel != SEL_HOLD) |
                  (MultoRF == M2RF_HI) | (MultoRF == M2RF_LO);
  assign stall  = div_busy & valid & md_req;
  assign accept = valid & ~stall;

  assign div_zero  = accept & div_en & (rt_data == '0);
  assign div_start = accept & div_en & (rt_data != '0);

  assign op_a    = {{WIDTH{multiply[0] & rs_data[WIDTH-1]}}, rs_data};
  assign op_b    = {{WIDTH{multiply[0] & rt_data[WIDTH-1]}}, rt_data};
  assign product = op_a * op_b;

  md_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .signed_i  (divide[0]),
    .dividend_i(rs_data),
    .divisor_i (rt_data),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = div_rem;
      lo_d = div_quot;
    end else if (div_zero) begin
      hi_d = rs_data;
      lo_d = '1;
    end else if (accept && !div_en) begin
      unique case (HI_sel)
        SEL_RS:            hi_d = rs_data;
        SEL_MUL:           if (mul_en) hi_d = product[2*WIDTH-1:WIDTH];
        SEL_DIV, SEL_HOLD: hi_d = hi_q;
      endcase
      unique case (LO_sel)
        SEL_RS:            lo_d = rs_data;
        SEL_MUL:           if (mul_en) lo_d = product[WIDTH-1:0];
        SEL_DIV, SEL_HOLD: lo_d = lo_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    md_rdata = '0;
    unique case (MultoRF)
      M2RF_NONE: md_rdata = '0;
      M2RF_MUL:  md_rdata = product[WIDTH-1:0];
      M2RF_HI:   md_rdata = hi_q;
      M2RF_LO:   md_rdata = lo_q;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = div_busy;

endmodule
